matrix_column_scanner: RTL

Display-side consumer of the three 7-bit column words produced by the matrix display-mode selector (water/irrigation). Snapshots one complete frame, then time-multiplexes the columns onto the physical 3x7 LED matrix pins. Each column is driven one-hot for a fixed dwell, followed by a ghost-suppression blank interval. Sits between the display-mode selector and the top-level matrix pins.

---
 rtl/matrix_pkg.sv | 24 ++
 rtl/matrix_column_scanner_timer.sv | 34 +++
 rtl/matrix_column_scanner.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, scanner state encoding and off-pattern helpers for the
// 3x7 LED matrix column scanner.
package matrix_pkg;

    localparam int MATRIX_COLS = 3;
    localparam int MATRIX_ROWS = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRIVE = 2'd2,
        BLANK = 2'd3
    } scan_state_t;

    // An "off" pin carries the inactive level, which is the polarity bit itself.
    function automatic logic [MATRIX_ROWS-1:0] rows_off(input logic active_low);
        return {MATRIX_ROWS{active_low}};
    endfunction

    function automatic logic [MATRIX_COLS-1:0] cols_off(input logic active_low);
        return {MATRIX_COLS{active_low}};
    endfunction

endpackage

// File: rtl/matrix_column_scanner_timer.sv
// Loadable down-counter shared by the DRIVE and BLANK intervals; done is high
// during the last cycle of an interval started with load_value = length - 1.
module scan_interval_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;
    logic             running;

    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            count   <= load_value;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign done = running && (count == '0);

endmodule

// File: rtl/matrix_column_scanner.sv
// Snapshots one frame of three column words and time-multiplexes them onto the
// physical matrix pins: one-hot column dwell followed by a ghost-suppression blank.
module matrix_column_scanner
    import matrix_pkg::*;
#(
    parameter int DWELL_CYCLES    = 50000,
    parameter int BLANK_CYCLES    = 4,
    parameter int ROWS_ACTIVE_LOW = 1,
    parameter int COLS_ACTIVE_LOW = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [MATRIX_ROWS-1:0] column_2,
    input  logic [MATRIX_ROWS-1:0] column_1,
    input  logic [MATRIX_ROWS-1:0] column_0,
    output logic [MATRIX_ROWS-1:0] matrix_rows,
    output logic [MATRIX_COLS-1:0] matrix_cols,
    output logic [1:0]             column_index,
    output logic                   frame_start
);

    localparam int MAX_COUNT = (DWELL_CYCLES > BLANK_CYCLES)
                             ? ((DWELL_CYCLES > 2) ? DWELL_CYCLES : 2)
                             : ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
    localparam int CW = $clog2(MAX_COUNT);

    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    localparam logic [MATRIX_ROWS-1:0] ROW_OFF = rows_off(ROWS_ACTIVE_LOW != 0);
    localparam logic [MATRIX_COLS-1:0] COL_OFF = cols_off(COLS_ACTIVE_LOW != 0);

    scan_state_t            state;
    scan_state_t            next_state;
    logic [1:0]             next_index;
    logic                   timer_start;
    logic [CW-1:0]          timer_load;
    logic                   timer_done;
    logic                   load_frame;
    logic                   end_of_column;
    logic [MATRIX_ROWS-1:0] frame [MATRIX_COLS];
    logic [MATRIX_ROWS-1:0] next_word;

    scan_interval_timer #(
        .WIDTH (CW)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .start      (timer_start),
        .load_value (timer_load),
        .done       (timer_done)
    );

    always_comb begin
        next_state    = state;
        next_index    = column_index;
        timer_start   = 1'b0;
        timer_load    = DWELL_LOAD;
        load_frame    = 1'b0;
        end_of_column = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                load_frame  = 1'b1;
                next_state  = DRIVE;
                next_index  = 2'd0;
                timer_start = 1'b1;
            end
            DRIVE: begin
                if (timer_done) begin
                    if (BLANK_CYCLES > 0) begin
                        next_state  = BLANK;
                        timer_start = 1'b1;
                        timer_load  = BLANK_LOAD;
                    end else begin
                        end_of_column = 1'b1;
                    end
                end
            end
            BLANK: begin
                if (timer_done) begin
                    end_of_column = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase

        // enable only matters once the last column of a frame has finished.
        if (end_of_column) begin
            if (column_index < 2'd2) begin
                next_index  = column_index + 2'd1;
                next_state  = DRIVE;
                timer_start = 1'b1;
                timer_load  = DWELL_LOAD;
            end else if (enable) begin
                next_state = LOAD;
                next_index = 2'd0;
            end else begin
                next_state = IDLE;
                next_index = 2'd0;
            end
        end
    end

    // The first column is shown on the same edge that captures it.
    always_comb begin
        next_word = '0;
        case (next_index)
            2'd0:    next_word = load_frame ? column_0 : frame[0];
            2'd1:    next_word = frame[1];
            default: next_word = frame[2];
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            column_index <= 2'd0;
            frame_start  <= 1'b0;
            matrix_rows  <= ROW_OFF;
            matrix_cols  <= COL_OFF;
            for (int i = 0; i < MATRIX_COLS; i++) begin
                frame[i] <= '0;
            end
        end else begin
            state        <= next_state;
            column_index <= next_index;
            frame_start  <= (next_state == LOAD);
            if (load_frame) begin
                frame[0] <= column_0;
                frame[1] <= column_1;
                frame[2] <= column_2;
            end
            if (next_state == DRIVE) begin
                matrix_rows <= next_word ^ ROW_OFF;
                matrix_cols <= (3'b001 << next_index) ^ COL_OFF;
            end else begin
                matrix_rows <= ROW_OFF;
                matrix_cols <= COL_OFF;
            end
        end
    end

endmodule
